// File: rtl/rgb_playback_ctrl.sv
// Colour-word sequencer: pops FIFO words, splits them into R/G/B duties and
// holds each word for a programmable number of PWM periods.
module rgb_playback_ctrl #(
    parameter int DATA_W  = 12,
    parameter int DWELL_W = 4,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                stop,
    input  logic                step,
    input  logic                mode,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                fifo_empty,
    input  logic [DATA_W-1:0]   fifo_rddata,
    output logic                fifo_rden,
    output logic [DATA_W/3-1:0] duty_r,
    output logic [DATA_W/3-1:0] duty_g,
    output logic [DATA_W/3-1:0] duty_b,
    output logic                busy,
    output logic                underrun,
    output logic [CNT_W-1:0]    word_cnt
);

    localparam int N = DATA_W / 3;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_DATA, LOAD, HOLD, PAUSE, STARVE
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               underrun_q, underrun_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0] limit_q, limit_d;
    logic               rden;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            word_q      <= '0;
            underrun_q  <= 1'b0;
            cnt_q       <= '0;
            dwell_cnt_q <= '0;
            limit_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            word_q      <= word_d;
            underrun_q  <= underrun_d;
            cnt_q       <= cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            limit_q     <= limit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        word_d      = word_q;
        underrun_d  = underrun_q;
        cnt_d       = cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        limit_d     = limit_q;
        rden        = 1'b0;

        // stop overrides everything, including a same-cycle start or a pending read
        if (stop) begin
            state_d = IDLE;
            word_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = FETCH;
                        mode_d     = mode;
                        cnt_d      = '0;
                        underrun_d = 1'b0;
                    end
                end
                FETCH: begin
                    if (!fifo_empty) begin
                        rden    = 1'b1;
                        state_d = WAIT_DATA;
                    end else if (mode_q) begin
                        underrun_d = 1'b1;
                        state_d    = STARVE;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                WAIT_DATA: state_d = LOAD;
                LOAD: begin
                    word_d      = fifo_rddata;
                    cnt_d       = cnt_q + CNT_W'(1);
                    limit_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
                    dwell_cnt_d = '0;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (tick) begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                        if (dwell_cnt_d == limit_q)
                            state_d = mode_q ? FETCH : PAUSE;
                    end
                end
                PAUSE: begin
                    if (step)
                        state_d = FETCH;
                end
                STARVE: begin
                    if (!fifo_empty) begin
                        rden    = 1'b1;
                        state_d = WAIT_DATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fifo_rden = rden;
    assign duty_r    = word_q[N-1:0];
    assign duty_g    = word_q[2*N-1:N];
    assign duty_b    = word_q[3*N-1:2*N];
    assign busy      = (state_q != IDLE);
    assign underrun  = underrun_q;
    assign word_cnt  = cnt_q;

endmodule

// File: doc/rgb_playback_ctrl.md
Name: rgb_playback_ctrl

Overview:
- Sequencer between the colour FIFO (fifo_v2) and the three PWM channels.
- Pops one DATA_W word at a time, splits it into R/G/B duty fields and holds each word for a programmable number of PWM periods.
- Runs in auto-advance or single-step mode.
- Reports busy, underrun and a played-word count for the LEDs and seven-segment display.

Parameters:
- DATA_W, 12, FIFO word width; must be a multiple of 3; field width N = DATA_W/3.
- DWELL_W, 4, width of the dwell (hold-length) input.
- CNT_W, 8, width of word_cnt.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-low reset.
- tick  in  1  one-clk strobe marking the end of one PWM period.
- start  in  1  one-clk pulse: begin playback.
- stop  in  1  one-clk pulse: abort playback.
- step  in  1  one-clk pulse: advance one word (single-step mode only).
- mode  in  1  0 = single-step, 1 = auto-advance; sampled at start.
- dwell  in  DWELL_W  hold length in ticks; 0 is treated as 1; sampled in LOAD.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rddata  in  DATA_W  FIFO read data; valid one clk after fifo_rden.
- fifo_rden  out  1  FIFO read enable, one-clk pulse.
- duty_r  out  N  red duty = word[N-1:0].
- duty_g  out  N  green duty = word[2N-1:N].
- duty_b  out  N  blue duty = word[3N-1:2N].
- busy  out  1  high in every state except IDLE.
- underrun  out  1  sticky: auto mode found the FIFO empty at fetch.
- word_cnt  out  CNT_W  words loaded since the last start.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All outputs 0: duties, fifo_rden, busy, underrun, word_cnt.
  - Dwell counter = 0.
- States: IDLE, FETCH, WAIT_DATA, LOAD, HOLD, PAUSE, STARVE.
- IDLE:
  - start=1 -> FETCH.
  - On that same edge: latch mode, clear word_cnt and underrun.
  - start while busy is ignored.
- FETCH:
  - fifo_empty=0 -> fifo_rden=1 for exactly this cycle, then WAIT_DATA.
  - fifo_empty=1 and auto mode -> underrun set, go to STARVE; rden stays 0.
  - fifo_empty=1 and single-step mode -> PAUSE; no underrun.
- WAIT_DATA: one cycle to cover FIFO read latency, then LOAD.
- LOAD:
  - Register fifo_rddata fields into duty_r/g/b.
  - word_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - Latch limit = max(dwell,1) and clear the dwell counter, then HOLD.
- HOLD:
  - Each tick increments the dwell counter.
  - On the tick that makes the counter equal limit: auto mode -> FETCH, single-step -> PAUSE.
- PAUSE: step=1 -> FETCH; duties hold.
- STARVE: re-check fifo_empty every cycle; when it is 0, behave as FETCH (rden=1 that cycle, then WAIT_DATA).
- Ticks outside HOLD are ignored. step outside PAUSE is ignored.
- Latency: start sampled at edge k -> fifo_rden high in cycle k+1 -> new duties visible after edge k+3.
- Duties hold their last value through FETCH, WAIT_DATA, PAUSE and STARVE, so there is no colour glitch between words.
- stop=1 in any state:
  - Next state is IDLE; duties cleared to 0.
  - A word in flight (WAIT_DATA) is discarded; word_cnt is not incremented.
  - underrun and word_cnt retain their values.
- start and stop in the same cycle: stop wins.
- fifo_rden is never asserted while fifo_empty=1 and never in two consecutive cycles.

Test Plan:
- Reset mid-HOLD with duties 0xA/0x5/0x3 -> all outputs 0 immediately (asynchronous), state IDLE.
- FIFO holds 0x3A5, 0x0F1; mode=1, dwell=2; pulse start:
  - rden at +1; duty_r=5, duty_g=A, duty_b=3 after +3.
  - Second rden on the 2nd tick; then duty_r=1, duty_g=F, duty_b=0.
  - FIFO now empty -> underrun=1, word_cnt=2, busy stays 1.
- dwell=0, auto mode -> each word held exactly 1 tick; step pulses in HOLD ignored.
- mode=0, 3 words queued, dwell=1:
  - One word loaded per step pulse; PAUSE after each tick.
  - Step with FIFO empty -> PAUSE again, underrun=0.
- stop in WAIT_DATA -> next cycle IDLE, duties 0, word_cnt unchanged; start+stop in the same cycle from IDLE -> stays IDLE.
- Play 256 words with CNT_W=8 -> word_cnt wraps to 0; fifo_rden count equals words loaded; no rden while empty.
